// File: rtl/seg_scan_driver_pkg.sv
// Shared types and segment encoding for seg_scan_driver.
// Segment order {g,f,e,d,c,b,a}, active-low.
package seg_scan_driver_pkg;

    typedef enum logic {BLANK, SHOW} state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg_enc(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_tick.sv
// Slot counter for seg_scan_driver: strobes at end of dead-time
// and at end of each digit slot.
module scan_tick_gen #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic end_blank,
    output logic end_slot
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;

    assign end_blank = (cnt == CW'(BLANK_CYC - 1));
    assign end_slot  = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (end_slot) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous update.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
import seg_scan_driver_pkg::*;

module seg_scan_driver #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [4*N_DIGITS-1:0] pend_val;
    logic [4*N_DIGITS-1:0] shadow_val;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  pend;
    logic [IW-1:0]         idx;
    state_t                state;
    logic                  end_blank;
    logic                  end_slot;
    logic                  last;
    logic                  boundary;
    logic [N_DIGITS-1:0]   suppress;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_sup;

    scan_tick_gen #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .end_blank (end_blank),
        .end_slot  (end_slot)
    );

    assign last     = (idx == IW'(N_DIGITS - 1));
    assign boundary = (state == SHOW) && end_slot && last;

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Walk down from the top digit; digit 0 is never suppressed.
    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (shadow_val[4*i +: 4] == 4'h0)
                       && !shadow_dp[i];
            suppress[i] = zero_run;
        end
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = shadow_val[4*i +: 4];
                cur_dp  = shadow_dp[i];
                cur_sup = suppress[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            // A load on the boundary edge stays pending for the next frame.
            if (load) begin
                pend <= 1'b1;
            end else if (boundary) begin
                pend <= 1'b0;
            end
            unique case (state)
                BLANK: begin
                    if (end_blank) begin
                        state <= SHOW;
                        if (!cur_sup) begin
                            an  <= ~(N_DIGITS'(1) << idx);
                            seg <= seg_enc(cur_nib);
                            dp  <= ~cur_dp;
                        end
                    end
                end
                SHOW: begin
                    if (end_slot) begin
                        state <= BLANK;
                        an    <= '1;
                        seg   <= SEG_OFF;
                        dp    <= 1'b1;
                        if (last) begin
                            idx        <= '0;
                            frame_done <= 1'b1;
                            if (pend) begin
                                shadow_val <= pend_val;
                                shadow_dp  <= pend_dp;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

endmodule
